id_ex_stage: RTL and testbench

- ID/EX pipeline register of the MIPS datapath, directly downstream of the register bank.
- Latches the two register-bank read ports, the extended immediate, register addresses and the decoded control bundle at posedge clk.
- Performs write-back bypass for same-cycle register-bank write/read collisions.
- Detects load-use hazards and inserts one bubble while stalling PC and IF/ID.

---
 rtl/id_ex_stage_if.sv | 49 ++++
 rtl/id_ex_stage.sv | 96 +++++++++
 tb/tb_id_ex_stage.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side decode fields and WB bypass inputs, EX-side registered outputs.
// The master drives ID/WB fields; the slave (the pipeline register) returns the EX fields and stall.
interface id_ex_stage_if #(
  parameter int REG_WIDTH     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int CTRL_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16
);
  logic                     id_valid;
  logic [31:0]              id_instr;
  logic [REG_WIDTH-1:0]     id_reg_a;
  logic [REG_WIDTH-1:0]     id_reg_b;
  logic [CTRL_WIDTH-1:0]    id_ctrl;
  logic                     id_mem_read;
  logic                     id_reg_write;
  logic                     id_uses_rt;
  logic [1:0]               id_reg_dst;
  logic                     id_imm_zext;
  logic                     wb_write_w;
  logic [REG_ADDR_BITS-1:0] wb_addr_reg_w;
  logic [REG_WIDTH-1:0]     wb_data;
  logic                     flush;
  logic                     stall;
  logic                     ex_valid;
  logic                     ex_mem_read;
  logic                     ex_reg_write;
  logic [REG_WIDTH-1:0]     ex_reg_a;
  logic [REG_WIDTH-1:0]     ex_reg_b;
  logic [REG_WIDTH-1:0]     ex_imm;
  logic [REG_ADDR_BITS-1:0] ex_rs;
  logic [REG_ADDR_BITS-1:0] ex_rt;
  logic [REG_ADDR_BITS-1:0] ex_dest;
  logic [CTRL_WIDTH-1:0]    ex_ctrl;
  logic [CNT_WIDTH-1:0]     stall_count;

  modport master (
    output id_valid, id_instr, id_reg_a, id_reg_b, id_ctrl, id_mem_read, id_reg_write,
           id_uses_rt, id_reg_dst, id_imm_zext, wb_write_w, wb_addr_reg_w, wb_data, flush,
    input  stall, ex_valid, ex_mem_read, ex_reg_write, ex_reg_a, ex_reg_b, ex_imm,
           ex_rs, ex_rt, ex_dest, ex_ctrl, stall_count
  );

  modport slave (
    input  id_valid, id_instr, id_reg_a, id_reg_b, id_ctrl, id_mem_read, id_reg_write,
           id_uses_rt, id_reg_dst, id_imm_zext, wb_write_w, wb_addr_reg_w, wb_data, flush,
    output stall, ex_valid, ex_mem_read, ex_reg_write, ex_reg_a, ex_reg_b, ex_imm,
           ex_rs, ex_rt, ex_dest, ex_ctrl, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass and load-use bubble; 1-cycle latency, stall holds PC/IF-ID.
// Optional STALL_COUNTER_EN adds a saturating bubble counter on stall_count (tied to 0 otherwise).
module id_ex_stage #(
  parameter int REG_WIDTH     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int CTRL_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  logic [REG_ADDR_BITS-1:0] rs;
  logic [REG_ADDR_BITS-1:0] rt;
  logic [REG_ADDR_BITS-1:0] rd;
  logic [REG_ADDR_BITS-1:0] dest_next;
  logic [15:0]              imm;
  logic [REG_WIDTH-1:0]     imm_next;
  logic [REG_WIDTH-1:0]     a_next;
  logic [REG_WIDTH-1:0]     b_next;
  logic                     hazard;
  logic                     bubble;
  logic                     unused_opcode;

  assign rs            = bus.id_instr[25:21];
  assign rt            = bus.id_instr[20:16];
  assign rd            = bus.id_instr[15:11];
  assign imm           = bus.id_instr[15:0];
  assign unused_opcode = ^bus.id_instr[31:26];

  assign hazard = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_dest != '0) &
                  ((bus.ex_dest == rs) | (bus.id_uses_rt & (bus.ex_dest == rt)));
  assign bus.stall = hazard & ~bus.flush;
  assign bubble    = bus.flush | hazard | ~bus.id_valid;

  // The bank reads the pre-write value on a same-cycle write, so forward WB data here.
  assign a_next = (bus.wb_write_w && bus.wb_addr_reg_w != '0 && bus.wb_addr_reg_w == rs)
                  ? bus.wb_data : bus.id_reg_a;
  assign b_next = (bus.wb_write_w && bus.wb_addr_reg_w != '0 && bus.wb_addr_reg_w == rt)
                  ? bus.wb_data : bus.id_reg_b;

  assign imm_next = bus.id_imm_zext ? {{(REG_WIDTH-16){1'b0}}, imm}
                                    : {{(REG_WIDTH-16){imm[15]}}, imm};

  always_comb begin
    dest_next = rt;
    case (bus.id_reg_dst)
      2'b01:   dest_next = rd;
      2'b10:   dest_next = REG_ADDR_BITS'(31);
      default: dest_next = rt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_ctrl      <= '0;
      bus.ex_reg_a     <= '0;
      bus.ex_reg_b     <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rs        <= '0;
      bus.ex_rt        <= '0;
      bus.ex_dest      <= '0;
    end else begin
      bus.ex_valid     <= 1'b1;
      bus.ex_mem_read  <= bus.id_mem_read;
      bus.ex_reg_write <= bus.id_reg_write;
      bus.ex_ctrl      <= bus.id_ctrl;
      bus.ex_reg_a     <= a_next;
      bus.ex_reg_b     <= b_next;
      bus.ex_imm       <= imm_next;
      bus.ex_rs        <= rs;
      bus.ex_rt        <= rt;
      bus.ex_dest      <= dest_next;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (bus.stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.stall_count = stall_cnt;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;

  localparam int RW = 32;
  localparam int AB = 5;
  localparam int CW = 8;
  localparam int NW = 16;

  typedef struct packed {
    logic          valid;
    logic          mem_read;
    logic          reg_write;
    logic [RW-1:0] reg_a;
    logic [RW-1:0] reg_b;
    logic [RW-1:0] imm;
    logic [AB-1:0] rs;
    logic [AB-1:0] rt;
    logic [AB-1:0] dest;
    logic [CW-1:0] ctrl;
  } ex_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef STALL_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage_if #(.REG_WIDTH(RW), .REG_ADDR_BITS(AB), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

  id_ex_stage #(.REG_WIDTH(RW), .REG_ADDR_BITS(AB), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic ex_t observe();
    return '{bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write, bus.ex_reg_a, bus.ex_reg_b,
             bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_ctrl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_instr = 0; bus.id_reg_a = 0; bus.id_reg_b = 0; bus.id_ctrl = 0;
    bus.id_mem_read = 0; bus.id_reg_write = 0; bus.id_uses_rt = 0; bus.id_reg_dst = 0;
    bus.id_imm_zext = 0; bus.wb_write_w = 0; bus.wb_addr_reg_w = 0; bus.wb_data = 0;
    bus.flush = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drive_instr(input logic [31:0] instr, input logic mem_read, input logic uses_rt);
    bus.id_valid = 1; bus.id_instr = instr; bus.id_mem_read = mem_read;
    bus.id_reg_write = 1; bus.id_uses_rt = uses_rt; bus.id_reg_dst = 2'b00;
    bus.id_ctrl = 8'hA5;
  endtask

  task automatic test_reset();
    ex_t obs;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      bus.id_valid = 1; bus.id_instr = $urandom; bus.id_reg_a = $urandom; bus.id_reg_b = $urandom;
      bus.id_ctrl = 8'($urandom); bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_uses_rt = 1;
      bus.id_reg_dst = 2'($urandom); bus.id_imm_zext = 1'($urandom); bus.flush = 0;
      tick();
    end
    obs = observe();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_ex: got %h expected 0", obs);
    end
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
    vectors++;
    if (bus.stall_count !== '0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
    end
    reset = 0;
    set_idle();
  endtask

  task automatic test_pass_through();
    do_reset();
    drive_instr(32'h2128FFFC, 0, 1);
    bus.id_reg_a = 5; bus.id_reg_b = 7; bus.id_imm_zext = 0;
    tick();
    vectors++;
    if ({bus.ex_valid, bus.ex_reg_a, bus.ex_reg_b, bus.ex_imm, bus.ex_dest, bus.ex_rs, bus.ex_ctrl} !==
        {1'b1, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd8, 5'd9, 8'hA5}) begin
      miscompares++;
      $display("FAIL pass_sext: got a=%h b=%h imm=%h dest=%0d rs=%0d v=%b expected a=5 b=7 imm=fffffffc dest=8 rs=9 v=1",
               bus.ex_reg_a, bus.ex_reg_b, bus.ex_imm, bus.ex_dest, bus.ex_rs, bus.ex_valid);
    end
    bus.id_imm_zext = 1;
    tick();
    vectors++;
    if (bus.ex_imm !== 32'h0000FFFC) begin
      miscompares++;
      $display("FAIL pass_zext: got %h expected 0000fffc", bus.ex_imm);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive_instr(32'h2128FFFC, 0, 1);
    bus.id_reg_a = 32'h11; bus.id_reg_b = 32'h22;
    bus.wb_write_w = 1; bus.wb_addr_reg_w = 9; bus.wb_data = 32'hDEADBEEF;
    tick();
    vectors++;
    if (bus.ex_reg_a !== 32'hDEADBEEF || bus.ex_reg_b !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_rs: got a=%h b=%h expected a=deadbeef b=22", bus.ex_reg_a, bus.ex_reg_b);
    end
    bus.wb_addr_reg_w = 0; bus.id_instr = 32'h2008FFFC;
    tick();
    vectors++;
    if (bus.ex_reg_a !== 32'h11) begin
      miscompares++;
      $display("FAIL bypass_r0: got %h expected 11", bus.ex_reg_a);
    end
    bus.wb_addr_reg_w = 8;
    tick();
    vectors++;
    if (bus.ex_reg_b !== 32'hDEADBEEF || bus.ex_reg_a !== 32'h11) begin
      miscompares++;
      $display("FAIL bypass_rt: got a=%h b=%h expected a=11 b=deadbeef", bus.ex_reg_a, bus.ex_reg_b);
    end
    set_idle();
  endtask

  task automatic test_dest_select();
    do_reset();
    drive_instr(32'h01091800, 0, 1);
    bus.id_reg_dst = 2'b10;
    tick();
    vectors++;
    if (bus.ex_dest !== 5'd31 || bus.ex_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL dest_31: got dest=%0d rw=%b expected dest=31 rw=1", bus.ex_dest, bus.ex_reg_write);
    end
    bus.id_reg_dst = 2'b01;
    tick();
    vectors++;
    if (bus.ex_dest !== 5'd3) begin
      miscompares++;
      $display("FAIL dest_rd: got %0d expected 3", bus.ex_dest);
    end
    set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_instr(32'h8C080000, 1, 0);
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_nostall: got %b expected 0", bus.stall);
    end
    tick();
    vectors++;
    if (bus.ex_mem_read !== 1'b1 || bus.ex_dest !== 5'd8) begin
      miscompares++;
      $display("FAIL lu_load: got mr=%b dest=%0d expected mr=1 dest=8", bus.ex_mem_read, bus.ex_dest);
    end
    drive_instr(32'h01091800, 0, 1);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_stall: got %b expected 1", bus.stall);
    end
    tick();
    vectors++;
    if (bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_bubble: got v=%b stall=%b expected v=0 stall=0", bus.ex_valid, bus.stall);
    end
    tick();
    vectors++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd8 || bus.stall_count !== NW'(CNT_ON)) begin
      miscompares++;
      $display("FAIL lu_enter: got v=%b rs=%0d cnt=%0d expected v=1 rs=8 cnt=%0d",
               bus.ex_valid, bus.ex_rs, bus.stall_count, CNT_ON);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    do_reset();
    drive_instr(32'h8C080000, 1, 0);
    tick();
    drive_instr(32'h8D090000, 1, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      stalls += int'(bus.stall);
      tick();
      stalls += int'(bus.stall);
      tick();
      if (k == 0) drive_instr(32'h01201800, 0, 0);
    end
    vectors++;
    if (stalls != 2 || bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd9 || bus.stall_count !== NW'(2 * CNT_ON)) begin
      miscompares++;
      $display("FAIL b2b: got stalls=%0d v=%b rs=%0d cnt=%0d expected stalls=2 v=1 rs=9 cnt=%0d",
               stalls, bus.ex_valid, bus.ex_rs, bus.stall_count, 2 * CNT_ON);
    end
    set_idle();
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive_instr(32'h8C080000, 1, 0);
    tick();
    drive_instr(32'h01091800, 0, 1);
    bus.flush = 1;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall: got %b expected 0", bus.stall);
    end
    tick();
    vectors++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_bubble: got v=%b rw=%b expected v=0 rw=0", bus.ex_valid, bus.ex_reg_write);
    end
    set_idle();
  endtask

  task automatic test_random();
    ex_t          exp;
    ex_t          obs;
    logic [NW-1:0] cnt;
    do_reset();
    exp = '0;
    cnt = '0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] instr;
      logic [4:0]  rs, rt, rd;
      logic        load_in_ex, reads_dest, hz, exp_stall, rst;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      instr = $urandom;
      instr[25:21] = rs; instr[20:16] = rt; instr[15:11] = rd;
      rst = ($urandom_range(0, 49) == 0);
      reset = rst;
      bus.id_valid = ($urandom_range(0, 7) != 0); bus.id_instr = instr;
      bus.id_reg_a = $urandom; bus.id_reg_b = $urandom; bus.id_ctrl = 8'($urandom);
      bus.id_mem_read = 1'($urandom); bus.id_reg_write = 1'($urandom); bus.id_uses_rt = 1'($urandom);
      bus.id_reg_dst = 2'($urandom); bus.id_imm_zext = 1'($urandom);
      bus.wb_write_w = 1'($urandom); bus.wb_addr_reg_w = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      bus.flush = ($urandom_range(0, 9) == 0);

      // A load in EX blocks an ID instruction that sources its (non-zero) destination.
      load_in_ex = exp.valid && exp.mem_read && exp.dest != 0;
      reads_dest = (exp.dest == rs) || (bus.id_uses_rt && exp.dest == rt);
      hz         = bus.id_valid && load_in_ex && reads_dest;
      exp_stall  = hz && !bus.flush;
      #1;
      vectors++;
      if (bus.stall !== exp_stall) begin
        miscompares++;
        $display("FAIL rand_stall[%0d]: got %b expected %b", n, bus.stall, exp_stall);
      end

      if (rst || bus.flush || hz || !bus.id_valid) begin
        exp = '0;
      end else begin
        exp.valid     = 1;
        exp.mem_read  = bus.id_mem_read;
        exp.reg_write = bus.id_reg_write;
        exp.ctrl      = bus.id_ctrl;
        exp.reg_a     = (bus.wb_write_w && bus.wb_addr_reg_w != 0 && bus.wb_addr_reg_w == rs) ? bus.wb_data : bus.id_reg_a;
        exp.reg_b     = (bus.wb_write_w && bus.wb_addr_reg_w != 0 && bus.wb_addr_reg_w == rt) ? bus.wb_data : bus.id_reg_b;
        exp.imm       = bus.id_imm_zext ? 32'(instr[15:0]) : 32'(signed'(instr[15:0]));
        exp.rs        = rs;
        exp.rt        = rt;
        exp.dest      = (bus.id_reg_dst == 2'b01) ? rd : (bus.id_reg_dst == 2'b10) ? 5'd31 : rt;
      end
      if (rst) cnt = '0;
      else if (CNT_ON && exp_stall && cnt != '1) cnt = cnt + 1'b1;

      tick();
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rand_ex[%0d]: got %h expected %h", n, obs, exp);
      end
      vectors++;
      if (bus.stall_count !== cnt) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", n, bus.stall_count, cnt);
      end
    end
    reset = 0;
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_pass_through();
    test_bypass();
    test_dest_select();
    test_load_use();
    test_back_to_back();
    test_flush_hazard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
